// File: rtl/timer16io.sv
// 16-bit down-counting interval timer for the 6801 bus: prescaled tick, auto-reload or
// one-shot, underflow flag with interrupt, and byte-wise atomic access to the 16-bit values.
module timer16io #(
    parameter int          PS_MAX      = 7,
    parameter logic [15:0] RELOAD_INIT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    output logic       irq,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs
);

    localparam int PW = (PS_MAX > 0) ? PS_MAX : 1;
    localparam logic [PW-1:0] PS_ONE = PW'(1);

    // Out-of-range prescale exponents saturate at PS_MAX.
    function automatic logic [2:0] clamp_ps(input logic [2:0] v);
        if (32'(v) > PS_MAX) begin
            return 3'(PS_MAX);
        end else begin
            return v;
        end
    endfunction

    logic          en_r, auto_r, ie_r, tof_r;
    logic [2:0]    ps_r;
    logic [15:0]   reload_r, count_r;
    logic [PW-1:0] presc_r;
    logic [7:0]    temp_h_r, latch_l_r;

    logic          wr_s, rd_s;
    logic          ctrl_wr_s, stat_wr_s, rld_h_wr_s, rld_l_wr_s, cnt_h_rd_s;
    logic [PW-1:0] mask_s;
    logic          tick_s, uf_s;
    logic          en_nxt_s;
    logic [15:0]   count_nxt_s, commit_s;

    assign wr_s       = cs && !rw;
    assign rd_s       = cs && rw;
    assign ctrl_wr_s  = wr_s && (AD == 3'd0);
    assign stat_wr_s  = wr_s && (AD == 3'd1);
    assign rld_h_wr_s = wr_s && (AD == 3'd2);
    assign rld_l_wr_s = wr_s && (AD == 3'd3);
    assign cnt_h_rd_s = rd_s && (AD == 3'd4);
    assign commit_s   = {temp_h_r, DI};

    // A CTRL write that stops the timer suppresses the tick on the same edge.
    assign mask_s = (PS_ONE << ps_r) - PS_ONE;
    assign tick_s = en_r && ((presc_r & mask_s) == mask_s) && !(ctrl_wr_s && !DI[0]);
    assign uf_s   = tick_s && (count_r == 16'h0000);

    // Next-state for EN and COUNT, including commit/reload collisions.
    always_comb begin
        en_nxt_s    = en_r;
        count_nxt_s = count_r;
        if (ctrl_wr_s) begin
            en_nxt_s = DI[0];
        end else if (uf_s && !auto_r) begin
            en_nxt_s = 1'b0;
        end else begin
            en_nxt_s = en_r;
        end

        if (rld_l_wr_s && !en_nxt_s) begin
            count_nxt_s = commit_s;
        end else if (tick_s) begin
            if (count_r != 16'h0000) begin
                count_nxt_s = count_r - 16'h0001;
            end else if (auto_r) begin
                count_nxt_s = rld_l_wr_s ? commit_s : reload_r;
            end else begin
                count_nxt_s = count_r;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_r      <= 1'b0;
            auto_r    <= 1'b0;
            ie_r      <= 1'b0;
            ps_r      <= 3'd0;
            tof_r     <= 1'b0;
            reload_r  <= RELOAD_INIT;
            count_r   <= RELOAD_INIT;
            presc_r   <= '0;
            temp_h_r  <= 8'h00;
            latch_l_r <= 8'h00;
        end else begin
            en_r    <= en_nxt_s;
            count_r <= count_nxt_s;
            if (ctrl_wr_s) begin
                auto_r  <= DI[1];
                ie_r    <= DI[2];
                ps_r    <= clamp_ps(DI[5:3]);
                presc_r <= '0;
            end else if (en_r) begin
                presc_r <= presc_r + PS_ONE;
            end else begin
                presc_r <= presc_r;
            end
            // Underflow beats a simultaneous clear.
            if (uf_s) begin
                tof_r <= 1'b1;
            end else if (stat_wr_s && DI[0]) begin
                tof_r <= 1'b0;
            end else begin
                tof_r <= tof_r;
            end
            if (rld_h_wr_s) begin
                temp_h_r <= DI;
            end else begin
                temp_h_r <= temp_h_r;
            end
            if (rld_l_wr_s) begin
                reload_r <= commit_s;
            end else begin
                reload_r <= reload_r;
            end
            if (cnt_h_rd_s) begin
                latch_l_r <= count_r[7:0];
            end else begin
                latch_l_r <= latch_l_r;
            end
        end
    end

    // Read mux; COUNT_L returns the byte captured by the last COUNT_H read.
    always_comb begin
        DO = 8'h00;
        case (AD)
            3'd0:    DO = {2'b00, ps_r, ie_r, auto_r, en_r};
            3'd1:    DO = {6'b000000, en_r, tof_r};
            3'd2:    DO = reload_r[15:8];
            3'd3:    DO = reload_r[7:0];
            3'd4:    DO = count_r[15:8];
            3'd5:    DO = latch_l_r;
            default: DO = 8'h00;
        endcase
    end

    assign irq = tof_r && ie_r;

endmodule

// File: tb/tb_timer16io.sv
// Scoreboard bench for timer16io: read stimulus queues expected DO/irq, a negedge
// monitor pops and compares whenever the CPU performs a read.
module tb_timer16io;

    logic       clk = 1'b0;
    logic       rst;
    logic       irq;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;

    typedef struct packed {
        logic [7:0] d;
        logic       irq;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    timer16io dut (
        .clk (clk),
        .rst (rst),
        .irq (irq),
        .AD  (AD),
        .DI  (DI),
        .DO  (DO),
        .rw  (rw),
        .cs  (cs)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [7:0] d, input logic i, input string nm);
        exp_t e;
        e.d   = d;
        e.irq = i;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] d, input logic i, input string nm);
        @(posedge clk);
        #1;
        cs = 1'b1; rw = 1'b1; AD = a; DI = 8'h00;
        push_exp(d, i, nm);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cs = 1'b0; rw = 1'b1;
        end
    endtask

    // Monitor: every CPU read cycle is checked against the oldest expectation.
    always @(negedge clk) begin
        if (cs && rw) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: AD=%0d DO=%02h irq=%b, no expectation queued", AD, DO, irq);
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (DO !== e.d || irq !== e.irq) begin
                    n_bad++;
                    $display("FAIL %s: DO=%02h irq=%b, expected DO=%02h irq=%b", nm, DO, irq, e.d, e.irq);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00; rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state and atomic RELOAD write
        rd(3'd0, 8'h00, 1'b0, "rst_ctrl");
        rd(3'd1, 8'h00, 1'b0, "rst_stat");
        rd(3'd4, 8'hFF, 1'b0, "rst_cnt_h");
        rd(3'd5, 8'hFF, 1'b0, "rst_cnt_l");
        wr(3'd2, 8'h12);
        rd(3'd2, 8'hFF, 1'b0, "rld_h_uncommitted");
        rd(3'd3, 8'hFF, 1'b0, "rld_l_uncommitted");
        wr(3'd3, 8'h34);
        rd(3'd2, 8'h12, 1'b0, "rld_h_commit");
        rd(3'd3, 8'h34, 1'b0, "rld_l_commit");
        rd(3'd4, 8'h12, 1'b0, "cnt_h_loaded");
        rd(3'd5, 8'h34, 1'b0, "cnt_l_loaded");
        rd(3'd6, 8'h00, 1'b0, "unused_6");
        rd(3'd7, 8'h00, 1'b0, "unused_7");

        // Auto-reload, RELOAD=3, PS=0: underflow every 4 clk
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h03);
        wr(3'd0, 8'h07);
        rd(3'd1, 8'h02, 1'b0, "auto_run");
        idle(2);
        rd(3'd1, 8'h02, 1'b0, "auto_pre_uf1");
        rd(3'd1, 8'h03, 1'b1, "auto_uf1");
        wr(3'd1, 8'h01);
        rd(3'd1, 8'h02, 1'b0, "auto_clr");
        rd(3'd1, 8'h02, 1'b0, "auto_pre_uf2");
        rd(3'd1, 8'h03, 1'b1, "auto_uf2");
        idle(2);
        wr(3'd1, 8'h01);
        rd(3'd1, 8'h03, 1'b1, "clr_race_set_wins");
        wr(3'd1, 8'h01);
        rd(3'd1, 8'h02, 1'b0, "clr_next_cycle");
        idle(1);
        rd(3'd1, 8'h03, 1'b1, "auto_uf4");
        wr(3'd0, 8'h03);
        rd(3'd1, 8'h03, 1'b0, "ie_off_irq_low");
        rd(3'd0, 8'h03, 1'b0, "ctrl_readback");
        wr(3'd0, 8'h07);
        rd(3'd1, 8'h03, 1'b1, "ie_on_irq_high");

        // Asynchronous reset while running with TOF set
        @(posedge clk);
        #1;
        rst = 1'b0; cs = 1'b1; rw = 1'b1; AD = 3'd1;
        push_exp(8'h00, 1'b0, "rst_async_stat_irq");
        rd(3'd0, 8'h00, 1'b0, "rst_ctrl_held");
        @(posedge clk);
        #1;
        rst = 1'b1; cs = 1'b0;
        rd(3'd4, 8'hFF, 1'b0, "rst_mid_cnt_h");
        rd(3'd5, 8'hFF, 1'b0, "rst_mid_cnt_l");
        rd(3'd3, 8'hFF, 1'b0, "rst_mid_rld_l");

        // One-shot, RELOAD=1, PS=2: TOF after 8 clk, EN clears
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h01);
        wr(3'd0, 8'h15);
        rd(3'd1, 8'h02, 1'b0, "oneshot_run");
        idle(6);
        rd(3'd1, 8'h02, 1'b0, "oneshot_pre_uf");
        rd(3'd1, 8'h01, 1'b1, "oneshot_uf");
        rd(3'd0, 8'h14, 1'b1, "oneshot_en_cleared");
        rd(3'd4, 8'h00, 1'b1, "oneshot_cnt_h");
        rd(3'd5, 8'h00, 1'b1, "oneshot_cnt_l");

        // Atomic COUNT read while decrementing from 0x0100 at PS=0
        wr(3'd2, 8'h01);
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h01);
        rd(3'd4, 8'h01, 1'b0, "atomic_cnt_h");
        idle(3);
        rd(3'd5, 8'h00, 1'b0, "atomic_cnt_l");
        rd(3'd2, 8'h01, 1'b0, "atomic_rld_h");
        rd(3'd3, 8'h00, 1'b0, "atomic_rld_l");
        // Stopping on a tick edge: count frozen at 0x0100-7
        wr(3'd0, 8'h00);
        rd(3'd4, 8'h00, 1'b0, "stop_cnt_h");
        rd(3'd5, 8'hF9, 1'b0, "stop_cnt_l");
        idle(2);
        rd(3'd5, 8'hF9, 1'b0, "stopped_hold");
        idle(2);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unconsumed_expectations: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
